// File: rtl/dsc_req_scheduler_if.sv
// Descriptor request scheduler bus bundle: head-pointer update events, the
// tail-table BRAM read port, descriptor-sent notifications, the outgoing
// descriptor request and the statistics counters.
interface dsc_req_scheduler_if #(
  parameter int QW = 13
) ();
  logic          head_upd_valid;
  logic          head_upd_ready;
  logic [QW-1:0] head_upd_queue_id;
  logic [31:0]   head_upd_head;
  logic          tail_rd_en;
  logic [QW-1:0] tail_rd_addr;
  logic [31:0]   tail_rd_data;
  logic          dsc_sent_valid;
  logic [QW-1:0] dsc_sent_queue_id;
  logic          dsc_req_valid;
  logic          dsc_req_ready;
  logic [QW-1:0] dsc_req_queue_id;
  logic [31:0]   suppressed_cnt;
  logic [31:0]   overflow_cnt;

  // scheduler side
  modport master (
    input  head_upd_valid, head_upd_queue_id, head_upd_head,
    output head_upd_ready,
    output tail_rd_en, tail_rd_addr,
    input  tail_rd_data,
    input  dsc_sent_valid, dsc_sent_queue_id,
    output dsc_req_valid, dsc_req_queue_id,
    input  dsc_req_ready,
    output suppressed_cnt, overflow_cnt
  );

  // environment side (software, tail BRAM, fpga2cpu)
  modport slave (
    output head_upd_valid, head_upd_queue_id, head_upd_head,
    input  head_upd_ready,
    input  tail_rd_en, tail_rd_addr,
    output tail_rd_data,
    output dsc_sent_valid, dsc_sent_queue_id,
    input  dsc_req_valid, dsc_req_queue_id,
    output dsc_req_ready,
    input  suppressed_cnt, overflow_cnt
  );
endinterface

// File: rtl/dsc_req_scheduler.sv
// Descriptor request scheduler. Each software head update triggers a tail
// lookup; if the queue has work (tail != head), no descriptor for it is
// already outstanding and it was not served during the lookup, its id is
// queued. Queued ids whose pending bit was cleared meanwhile are dropped
// silently at the FIFO head instead of generating a request.
module dsc_req_scheduler #(
  parameter int NB_QUEUES  = 8192,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  dsc_req_scheduler_if.master bus
);
  localparam int QW = $clog2(NB_QUEUES);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WAIT, CMP} state_t;

  state_t          state;
  logic [QW-1:0]   lat_id;
  logic [31:0]     lat_head;
  logic            abort;
  logic            upd_ready;
  logic            rd_en;

  logic [NB_QUEUES-1:0] pending;

  logic [QW-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full;
  logic [QW-1:0]   fifo_head;
  logic            head_pend;

  logic            sent_hit, cmp_qual, hs, sup, pop, push, ovf;
  logic [31:0]     sup_cnt, ovf_cnt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head = mem[rd_ptr[AW-1:0]];
  assign head_pend = pending[fifo_head];

  // A descriptor sent for the queue under lookup makes the tail read stale.
  assign sent_hit = bus.dsc_sent_valid && (bus.dsc_sent_queue_id == lat_id);
  assign cmp_qual = (state == CMP) && (bus.tail_rd_data != lat_head) &&
                    !abort && !sent_hit && !pending[lat_id];

  assign hs   = bus.dsc_req_valid && bus.dsc_req_ready;
  assign sup  = !empty && !head_pend;
  assign pop  = hs || sup;
  // a pop in the same cycle frees the slot for a push even when full
  assign push = cmp_qual && (!full || pop);
  assign ovf  = cmp_qual && full && !pop;

  assign bus.head_upd_ready   = upd_ready;
  assign bus.tail_rd_en       = rd_en;
  assign bus.tail_rd_addr     = lat_id;
  assign bus.dsc_req_valid    = !empty && head_pend;
  assign bus.dsc_req_queue_id = fifo_head;
  assign bus.suppressed_cnt   = sup_cnt;
  assign bus.overflow_cnt     = ovf_cnt;

  // Lookup FSM: accept update, issue one BRAM read, wait out its latency, decide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_id    <= '0;
      lat_head  <= '0;
      abort     <= 1'b0;
      upd_ready <= 1'b0;
      rd_en     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          upd_ready <= 1'b1;
          if (bus.head_upd_valid && upd_ready) begin
            lat_id    <= bus.head_upd_queue_id;
            lat_head  <= bus.head_upd_head;
            abort     <= 1'b0;
            upd_ready <= 1'b0;
            rd_en     <= 1'b1;
            state     <= RD;
          end
        end
        RD: begin
          rd_en <= 1'b0;
          if (sent_hit) abort <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (sent_hit) abort <= 1'b1;
          state <= CMP;
        end
        default: begin
          upd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Pending bits: set on push, clears are applied last so they win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (push)               pending[lat_id]                <= 1'b1;
      if (bus.dsc_sent_valid) pending[bus.dsc_sent_queue_id] <= 1'b0;
      if (hs)                 pending[fifo_head]             <= 1'b0;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= lat_id;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sup_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (sup && (sup_cnt != 32'hFFFF_FFFF)) sup_cnt <= sup_cnt + 1'b1;
      if (ovf && (ovf_cnt != 32'hFFFF_FFFF)) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
endmodule

// File: doc/dsc_req_scheduler.md
DSC_REQ_SCHEDULER -- requirements
Module: dsc_req_scheduler

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter NB_QUEUES, default 8192, number of packet queues (power of 2); QW = $clog2(NB_QUEUES).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, request FIFO entries (power of 2).
REQ-004 The block SHALL have port clk  in  1  clock.
REQ-005 The block SHALL have port rst_n  in  1  async active-low reset.
REQ-006 The block SHALL have port head_upd_valid / head_upd_ready  in / out  1 / 1  software head-pointer write event handshake.
REQ-007 The block SHALL have port head_upd_queue_id / head_upd_head  in  QW / 32  queue index and new head value.
REQ-008 The block SHALL have port tail_rd_en / tail_rd_addr  out  1 / QW  tail-table BRAM read request.
REQ-009 The block SHALL have port tail_rd_data  in  32  tail value, valid exactly 2 cycles after tail_rd_en.
REQ-010 The block SHALL have port dsc_sent_valid / dsc_sent_queue_id  in  1 / QW  fpga2cpu emitted a descriptor for that queue.
REQ-011 The block SHALL have port dsc_req_valid / dsc_req_ready / dsc_req_queue_id  out / in / out  1 / 1 / QW  descriptor request to fpga2cpu.
REQ-012 The block SHALL have port suppressed_cnt / overflow_cnt  out  32 / 32  statistics counters.

Function
REQ-013 The block SHALL implement FSM states IDLE, RD, WAIT, CMP; head_upd_ready = 1 only in IDLE.
REQ-014 The block SHALL latch queue id and head in IDLE on head_upd_valid, then move to RD.
REQ-015 The block SHALL, in RD, assert tail_rd_en for exactly one cycle with tail_rd_addr = latched id, then move to WAIT, then CMP, then IDLE; an accepted update at cycle T is decided in CMP at T+3, and ready returns at T+4.
REQ-016 The block SHALL keep a pending bit per queue; it SHALL set an abort flag if dsc_sent_valid names the latched id in any of the RD, WAIT or CMP cycles.
REQ-017 The block SHALL, in CMP, push the id into the FIFO and set pending only if: tail_rd_data != latched head (full 32-bit compare), abort clear, pending[id] clear, FIFO not full.
REQ-018 The block SHALL leave the FIFO and pending unchanged when CMP finds pending[id] already set (dedupe).
REQ-019 The block SHALL drop the entry and increment overflow_cnt once when CMP qualifies a push but the FIFO is full.
REQ-020 The block SHALL clear pending[q] on dsc_sent_valid for queue q in every state.
REQ-021 The block SHALL, when the FIFO head entry has pending clear, pop it without asserting dsc_req_valid and increment suppressed_cnt; this is one pop per cycle.
REQ-022 The block SHALL assert dsc_req_valid when the FIFO is non-empty and pending[head entry] is set; dsc_req_queue_id = head entry.
REQ-023 The block SHALL hold dsc_req_valid and dsc_req_queue_id stable until handshake unless pending is cleared by dsc_sent, in which case REQ-021 applies.
REQ-024 The block SHALL, on dsc_req handshake, pop the entry and clear its pending bit.
REQ-025 The block SHALL, on a same-cycle set (CMP) and clear (dsc_sent or handshake) for the same queue, have the clear win with no push.
REQ-026 The block SHALL allow a simultaneous push and pop, with no occupancy change when the FIFO is full.
REQ-027 The block SHALL saturate both counters at 2^32-1.

Reset
REQ-028 The block SHALL, while rst_n is low: FSM IDLE, pending all 0, FIFO empty, counters 0, and head_upd_ready, tail_rd_en, dsc_req_valid all 0.
REQ-029 The block SHALL discard any in-flight lookup and any tail_rd_data returning after reset deassertion.

Verification
REQ-030 The bench SHALL cover: q=5, head=0x40, tail=0x80 -> tail_rd_en at T+1 with addr 5, dsc_req_valid with id 5 at T+4, and pending[5] cleared after handshake.
REQ-031 The bench SHALL cover: q=3, head=0x80, tail=0x80 -> no push, dsc_req_valid stays 0, head_upd_ready back to 1 at T+4.
REQ-032 The bench SHALL cover: two updates to q=7 with tail != head and dsc_req_ready held 0 -> one FIFO entry; then dsc_sent q=7 -> entry suppressed, suppressed_cnt=1, no dsc_req_valid.
REQ-033 The bench SHALL cover: dsc_sent q=9 in the WAIT cycle of a q=9 lookup with tail != head -> no push, pending[9]=0.
REQ-034 The bench SHALL cover: 17 distinct queues needing descriptors with dsc_req_ready=0 -> 16 queued, overflow_cnt=1; then drain -> 16 requests in arrival order.
REQ-035 The bench SHALL cover: rst_n low for one cycle during WAIT -> all outputs 0 immediately; after release, the returning tail_rd_data is ignored and the FIFO is empty.
